bounce_counter_ctrl: RTL and testbench

//  Push-button-driven bounded up/down counter for the board front panel: two raw buttons (step, clear)
//  are synchronised and debounced, and each debounced press moves a WIDTH-bit counter. All logic is

---
 rtl/bcc_pkg.sv | 28 ++
 rtl/btn_debounce_edge.sv | 85 ++++++++
 rtl/bounce_counter_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bounce_counter_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcc_pkg.sv
// Shared encodings and helpers for the front-panel bounce counter.
// Optional auto-repeat is enabled in the top by defining BCC_AUTOREPEAT_EN.
package bcc_pkg;

  typedef enum logic [1:0] {
    MODE_PINGPONG = 2'b00,
    MODE_UPWRAP   = 2'b01,
    MODE_DOWNWRAP = 2'b10,
    MODE_HOLD     = 2'b11
  } bcc_mode_e;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'b00,
    DB_WAIT_HI = 2'b01,
    DB_HELD    = 2'b10,
    DB_WAIT_LO = 2'b11
  } db_state_e;

  // Width able to hold value-1; never less than one bit.
  function automatic int bcc_clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w = w + 1;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce_edge.sv
// Two-flop synchroniser plus tick-sampled debounce FSM for one raw button.
// level is the debounced state; press is a one-cycle strobe on each accepted press.
//
// state   | meaning
// IDLE    | released and stable
// WAIT_HI | raw high, counting stable ticks before accepting the press
// HELD    | pressed and stable
// WAIT_LO | raw low, counting stable ticks before accepting the release
module btn_debounce_edge
  import bcc_pkg::*;
#(
  parameter int STABLE_TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int            CW       = bcc_clog2(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          cnt_done;

  assign btn_s    = sync_q[1];
  assign cnt_done = tick && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= DB_IDLE;
      cnt_q   <= CNT_LOAD;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // The stable-tick counter reloads in the steady states so every wait starts fresh.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DB_IDLE: begin
        cnt_d = CNT_LOAD;
        if (btn_s) state_d = DB_WAIT_HI;
      end
      DB_WAIT_HI: begin
        if (!btn_s)        state_d = DB_IDLE;
        else if (cnt_done) state_d = DB_HELD;
        else if (tick)     cnt_d   = cnt_q - CW'(1);
      end
      DB_HELD: begin
        cnt_d = CNT_LOAD;
        if (!btn_s) state_d = DB_WAIT_LO;
      end
      DB_WAIT_LO: begin
        if (btn_s)         state_d = DB_HELD;
        else if (cnt_done) state_d = DB_IDLE;
        else if (tick)     cnt_d   = cnt_q - CW'(1);
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = CNT_LOAD;
      end
    endcase
  end

  always_comb begin
    level   = (state_q == DB_HELD) || (state_q == DB_WAIT_LO);
    press_d = (state_q == DB_WAIT_HI) && (state_d == DB_HELD);
    press   = press_q;
  end

endmodule

// File: rtl/bounce_counter_ctrl.sv
// Debounced push-button bounded up/down counter with a shared sample-tick divider.
// Define BCC_AUTOREPEAT_EN to get a repeated step every REPEAT_TICKS ticks while step is held.
module bounce_counter_ctrl
  import bcc_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CNT_MIN      = 0,
  parameter int CNT_MAX      = 18,
  parameter int TICK_DIV     = 8192,
  parameter int STABLE_TICKS = 3,
  parameter int REPEAT_TICKS = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             btn_clr,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             step_pulse,
  output logic             at_min,
  output logic             at_max
);

  localparam int               DIV_W    = bcc_clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(CNT_MIN);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(CNT_MAX);
  localparam logic [WIDTH-1:0] MIN_P1   = WIDTH'(CNT_MIN + 1);
  localparam logic [WIDTH-1:0] MAX_M1   = WIDTH'(CNT_MAX - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  if (WIDTH < 2 || WIDTH > 16 || CNT_MIN < 0 || CNT_MIN >= CNT_MAX ||
      CNT_MAX >= (1 << WIDTH) || TICK_DIV < 2 || STABLE_TICKS < 1 ||
      REPEAT_TICKS < 1) begin : g_param_check
    $error("bounce_counter_ctrl: illegal parameter set");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             step_level, step_press;
  logic             clr_level, clr_press;
  logic             step_evt;
  logic             unused_levels;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             step_pulse_q, step_pulse_d;
  bcc_mode_e        mode_e;

  assign mode_e        = bcc_mode_e'(mode);
  assign tick          = (div_q == '0);
  assign div_d         = tick ? DIV_LOAD : div_q - DIV_W'(1);
  assign unused_levels = clr_level ^ step_level;

  btn_debounce_edge #(.STABLE_TICKS(STABLE_TICKS)) u_db_step (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .btn_raw (btn_step),
    .level   (step_level),
    .press   (step_press)
  );

  btn_debounce_edge #(.STABLE_TICKS(STABLE_TICKS)) u_db_clr (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .btn_raw (btn_clr),
    .level   (clr_level),
    .press   (clr_press)
  );

`ifdef BCC_AUTOREPEAT_EN
  localparam int             REP_W    = bcc_clog2(REPEAT_TICKS);
  localparam logic [REP_W-1:0] REP_LOAD = REP_W'(REPEAT_TICKS - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             rep_fire;

  // Counts ticks from the initial press; restarts on each press and whenever released.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (!step_level || step_press) begin
      rep_d = REP_LOAD;
    end else if (tick) begin
      if (rep_q == '0) begin
        rep_fire = 1'b1;
        rep_d    = REP_LOAD;
      end else begin
        rep_d = rep_q - REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_q <= REP_LOAD;
    else       rep_q <= rep_d;
  end

  assign step_evt = step_press | rep_fire;
`else
  assign step_evt = step_press;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= DIV_LOAD;
      q_q          <= MIN_V;
      dir_q        <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      q_q          <= q_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  always_comb begin
    q_d          = q_q;
    dir_d        = dir_q;
    step_pulse_d = 1'b0;
    if (clr_press) begin
      q_d   = MIN_V;
      dir_d = 1'b0;
    end else if (step_evt) begin
      case (mode_e)
        MODE_PINGPONG: begin
          step_pulse_d = 1'b1;
          // Out-of-direction endpoints (entered via a mode change) turn around immediately.
          if (!dir_q) begin
            if (q_q >= MAX_V) begin
              q_d   = MAX_M1;
              dir_d = (MAX_M1 != MIN_V);
            end else begin
              q_d   = q_q + ONE;
              dir_d = ((q_q + ONE) == MAX_V);
            end
          end else begin
            if (q_q <= MIN_V) begin
              q_d   = MIN_P1;
              dir_d = (MIN_P1 == MAX_V);
            end else begin
              q_d   = q_q - ONE;
              dir_d = ((q_q - ONE) != MIN_V);
            end
          end
        end
        MODE_UPWRAP: begin
          step_pulse_d = 1'b1;
          q_d          = (q_q >= MAX_V) ? MIN_V : q_q + ONE;
          dir_d        = 1'b0;
        end
        MODE_DOWNWRAP: begin
          step_pulse_d = 1'b1;
          q_d          = (q_q <= MIN_V) ? MAX_V : q_q - ONE;
          dir_d        = 1'b1;
        end
        default: begin
          q_d   = q_q;
          dir_d = dir_q;
        end
      endcase
    end
  end

  assign q          = q_q;
  assign dir        = dir_q;
  assign step_pulse = step_pulse_q;
  assign at_min     = (q_q == MIN_V);
  assign at_max     = (q_q == MAX_V);

endmodule

// File: tb/tb_bounce_counter_ctrl.sv
// Self-checking bench for bounce_counter_ctrl: vector table, corner sequences and a random run.
module tb_bounce_counter_ctrl;

  localparam int WIDTH = 8;
  localparam int MINV  = 0;
  localparam int MAXV  = 18;
  localparam int SPAN  = MAXV - MINV + 1;
  localparam int SETTLE = 24;
`ifdef BCC_AUTOREPEAT_EN
  localparam int AR_EXP     = 5;
  localparam int HOLD_CLEAN = 16;
`else
  localparam int AR_EXP     = 1;
  localparam int HOLD_CLEAN = 40;
`endif

  logic             clk;
  logic             reset;
  logic             btn_step;
  logic             btn_clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] q;
  logic             dir;
  logic             step_pulse;
  logic             at_min;
  logic             at_max;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  int mq, mdir;

  typedef struct {
    logic [1:0] m;
    bit         s;
    bit         c;
    int         eq;
    int         edir;
    int         epulses;
  } vec_t;

  vec_t tbl [18];

  bounce_counter_ctrl #(
    .WIDTH(WIDTH), .CNT_MIN(MINV), .CNT_MAX(MAXV),
    .TICK_DIV(4), .STABLE_TICKS(3), .REPEAT_TICKS(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_step   (btn_step),
    .btn_clr    (btn_clr),
    .mode       (mode),
    .q          (q),
    .dir        (dir),
    .step_pulse (step_pulse),
    .at_min     (at_min),
    .at_max     (at_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (step_pulse) pulse_cnt = pulse_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] m, input bit s, input bit c, input int hold);
    @(negedge clk);
    mode     = m;
    btn_step = s;
    btn_clr  = c;
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    btn_clr  = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reference: a bouncing walk between the bounds, or modular wrap, from the current value.
  task automatic model_op(input logic [1:0] m, input bit s, input bit c, output int epulses);
    int stp;
    epulses = 0;
    if (c) begin
      mq = MINV; mdir = 0;
    end else if (s) begin
      case (m)
        2'b00: begin
          stp = mdir ? -1 : 1;
          if (mq + stp > MAXV || mq + stp < MINV) stp = -stp;
          mq   = mq + stp;
          mdir = (stp < 0) ? 1 : 0;
          if (mq == MAXV) mdir = 1;
          if (mq == MINV) mdir = 0;
          epulses = 1;
        end
        2'b01: begin
          mq = MINV + (mq - MINV + 1) % SPAN; mdir = 0; epulses = 1;
        end
        2'b10: begin
          mq = MINV + (mq - MINV + SPAN - 1) % SPAN; mdir = 1; epulses = 1;
        end
        default: epulses = 0;
      endcase
    end
  endtask

  initial begin
    int p0, ep, hold, kq, kdir;
    logic [1:0] rm;
    bit rs, rc;

    tbl[0]  = '{2'b01, 1, 0, 1,  0, 1};
    tbl[1]  = '{2'b10, 1, 0, 0,  1, 1};
    tbl[2]  = '{2'b10, 1, 0, 18, 1, 1};
    tbl[3]  = '{2'b01, 1, 0, 0,  0, 1};
    tbl[4]  = '{2'b11, 1, 0, 0,  0, 0};
    tbl[5]  = '{2'b11, 1, 0, 0,  0, 0};
    tbl[6]  = '{2'b11, 1, 0, 0,  0, 0};
    tbl[7]  = '{2'b10, 1, 0, 18, 1, 1};
    tbl[8]  = '{2'b11, 1, 0, 18, 1, 0};
    tbl[9]  = '{2'b00, 1, 0, 17, 1, 1};
    tbl[10] = '{2'b01, 1, 0, 18, 0, 1};
    tbl[11] = '{2'b00, 1, 0, 17, 1, 1};
    tbl[12] = '{2'b00, 0, 1, 0,  0, 0};
    tbl[13] = '{2'b10, 1, 0, 18, 1, 1};
    tbl[14] = '{2'b00, 0, 1, 0,  0, 0};
    tbl[15] = '{2'b01, 1, 0, 1,  0, 1};
    tbl[16] = '{2'b10, 1, 0, 0,  1, 1};
    tbl[17] = '{2'b00, 1, 0, 1,  0, 1};

    reset = 1'b1; btn_step = 1'b0; btn_clr = 1'b0; mode = 2'b00;
    repeat (4) @(negedge clk);
    check("rst_q", int'(q), MINV);
    check("rst_dir", int'(dir), 0);
    check("rst_pulse", int'(step_pulse), 0);
    check("rst_at_min", int'(at_min), 1);
    check("rst_at_max", int'(at_max), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    p0 = pulse_cnt;
    do_op(2'b00, 1, 0, HOLD_CLEAN);
    check("clean_pulses", pulse_cnt - p0, 1);
    check("clean_q", int'(q), 1);
    check("clean_dir", int'(dir), 0);
    check("clean_at_min", int'(at_min), 0);

    // Bounce before the press and on release.
    p0 = pulse_cnt;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      btn_step = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      btn_step = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    btn_step = 1'b1;
    repeat (HOLD_CLEAN) @(negedge clk);
    check("bounce_press_pulses", pulse_cnt - p0, 1);
    for (int i = 0; i < 5; i++) begin
      btn_step = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      btn_step = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    btn_step = 1'b0;
    repeat (SETTLE) @(negedge clk);
    check("bounce_total_pulses", pulse_cnt - p0, 1);
    check("bounce_q", int'(q), 2);

    // Full ping-pong turn from reset.
    do_reset();
    p0 = pulse_cnt;
    for (int k = 1; k <= 36; k++) begin
      do_op(2'b00, 1, 0, 16);
      kq   = (k <= 18) ? k : 36 - k;
      kdir = (k >= 18 && k < 36) ? 1 : 0;
      check($sformatf("pp_q_%0d", k), int'(q), kq);
      check($sformatf("pp_dir_%0d", k), int'(dir), kdir);
      if (k == 18) check("pp_at_max", int'(at_max), 1);
      if (k == 36) check("pp_at_min", int'(at_min), 1);
    end
    check("pp_pulses", pulse_cnt - p0, 36);

    for (int i = 0; i < 18; i++) begin
      p0 = pulse_cnt;
      do_op(tbl[i].m, tbl[i].s, tbl[i].c, 16);
      check($sformatf("tbl%0d_q", i), int'(q), tbl[i].eq);
      check($sformatf("tbl%0d_dir", i), int'(dir), tbl[i].edir);
      check($sformatf("tbl%0d_pulses", i), pulse_cnt - p0, tbl[i].epulses);
      check($sformatf("tbl%0d_at_max", i), int'(at_max), (tbl[i].eq == MAXV) ? 1 : 0);
    end

    // Step and clear accepted in the same cycle at q=7.
    do_reset();
    for (int i = 0; i < 7; i++) do_op(2'b01, 1, 0, 16);
    check("pre_both_q", int'(q), 7);
    p0 = pulse_cnt;
    do_op(2'b01, 1, 1, 16);
    check("both_q", int'(q), MINV);
    check("both_dir", int'(dir), 0);
    check("both_pulses", pulse_cnt - p0, 0);

    // Reset in the middle of WAIT_HI.
    do_op(2'b01, 1, 0, 16);
    check("pre_rst_q", int'(q), 1);
    p0 = pulse_cnt;
    @(negedge clk);
    btn_step = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_async_q", int'(q), MINV);
    @(negedge clk);
    btn_step = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (SETTLE) @(negedge clk);
    check("midrst_q", int'(q), MINV);
    check("midrst_pulses", pulse_cnt - p0, 0);

    // Button held across reset deassertion is a fresh press.
    p0 = pulse_cnt;
    @(negedge clk);
    btn_step = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (16) @(negedge clk);
    btn_step = 1'b0;
    repeat (SETTLE) @(negedge clk);
    check("held_rst_pulses", pulse_cnt - p0, 1);
    check("held_rst_q", int'(q), 1);

    // Long hold: repeats only when auto-repeat is built in.
    do_reset();
    p0 = pulse_cnt;
    @(negedge clk);
    mode     = 2'b01;
    btn_step = 1'b1;
    repeat (100) @(negedge clk);
    check("long_hold_pulses", pulse_cnt - p0, AR_EXP);
    check("long_hold_q", int'(q), AR_EXP);
    btn_step = 1'b0;
    repeat (SETTLE) @(negedge clk);

    // Random operations against the reference model.
    do_reset();
    mq = MINV; mdir = 0;
    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom_range(0, 3));
      rc = ($urandom_range(0, 5) == 0);
      rs = !rc || ($urandom_range(0, 1) == 1);
`ifdef BCC_AUTOREPEAT_EN
      hold = 16;
`else
      hold = 16 + $urandom_range(0, 24);
`endif
      model_op(rm, rs, rc, ep);
      p0 = pulse_cnt;
      do_op(rm, rs, rc, hold);
      check($sformatf("rnd%0d_q", i), int'(q), mq);
      check($sformatf("rnd%0d_dir", i), int'(dir), mdir);
      check($sformatf("rnd%0d_pulses", i), pulse_cnt - p0, ep);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
